// File: rtl/pck_arbiter.sv
// pck_arbiter: shared types and helpers for the frame arbiter
// Holds the FSM state type, a clog2 that never returns 0, and the rotating-priority search.
package pck_arbiter;

    typedef enum logic {IDLE, XFER} state_t;

    localparam int MAX_REQ = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Offsets are scanned from farthest to nearest so the nearest set bit after
    // `last` is what remains; `last` itself is the lowest-priority candidate.
    function automatic int next_grant(input logic [MAX_REQ-1:0] req, input int last, input int n);
        int idx;
        next_grant = last;
        for (int i = n; i >= 1; i--) begin
            idx = last + i;
            if (idx >= n) idx = idx - n;
            if (req[idx]) next_grant = idx;
        end
    endfunction

endpackage

// File: rtl/rr_pointer_arbiter.sv
// rr_pointer_arbiter: round-robin pick with a registered last-served pointer
// Ports: i_clk/i_rst_n clock and async active-low reset; i_req request bits;
// i_update/i_served load the last-served pointer; o_grant chosen index; o_any some request set.
module rr_pointer_arbiter
    import pck_arbiter::*;
#(
    parameter int N_REQ = 3,
    parameter int GW    = clog2_min1(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_update,
    input  logic [GW-1:0]    i_served,
    output logic [GW-1:0]    o_grant,
    output logic             o_any
);

    logic [GW-1:0] last;

    // Starting at N_REQ-1 makes requester 0 the first in line after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) last <= GW'(N_REQ - 1);
        else if (i_update) last <= i_served;
    end

    always_comb begin
        o_any   = |i_req;
        o_grant = GW'(next_grant(MAX_REQ'(i_req), int'(last), N_REQ));
    end

endmodule

// File: rtl/socket_frame_arbiter.sv
// socket_frame_arbiter: frame-granular round-robin sharing of one downstream socket
// Ports: i_clk/i_rst_n clock and async active-low reset; i_req_data/i_req_valid/o_req_ready
// per-requester words and pop strobes; o_data/o_valid/i_ready downstream push;
// o_grant_id current owner; o_sof/o_eof frame boundaries; o_busy frame in progress.
module socket_frame_arbiter
    import pck_arbiter::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 3,
    parameter int FRAME_LEN  = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [N_REQ-1:0]              i_req_valid,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [clog2_min1(N_REQ)-1:0]  o_grant_id,
    output logic                          o_sof,
    output logic                          o_eof,
    output logic                          o_busy
);

    localparam int GW = clog2_min1(N_REQ);
    localparam int CW = $clog2(FRAME_LEN + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [GW-1:0] pick;
    logic          any, xfer, hs, last_word;

    rr_pointer_arbiter #(.N_REQ(N_REQ), .GW(GW)) u_rr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req_valid),
        .i_update (hs && last_word),
        .i_served (o_grant_id),
        .o_grant  (pick),
        .o_any    (any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // The owner is latched only while idle, so the grant cannot move mid-frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            o_grant_id <= '0;
        end else begin
            cnt <= hs ? (last_word ? '0 : cnt + 1'b1) : cnt;
            if (!xfer && any) o_grant_id <= pick;
        end
    end

    always_comb begin
        xfer        = state == XFER;
        last_word   = cnt == CW'(FRAME_LEN - 1);
        o_valid     = xfer && i_req_valid[o_grant_id];
        hs          = o_valid && i_ready;
        o_req_ready = hs ? N_REQ'(1) << o_grant_id : '0;
        o_data      = xfer ? i_req_data[o_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
        o_sof       = o_valid && cnt == '0;
        o_eof       = o_valid && last_word;
        o_busy      = xfer;
        state_nx    = xfer ? ((hs && last_word) ? IDLE : XFER) : (any ? XFER : IDLE);
    end

endmodule

// File: tb/tb_socket_frame_arbiter.sv
// tb_socket_frame_arbiter: self-checking bench with vector table, directed corners and a reference model
module tb_socket_frame_arbiter;
    import pck_arbiter::*;

    localparam int DW = 16;
    localparam int NR = 3;
    localparam int FL = 5;
    localparam int GW = clog2_min1(NR);

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [NR*DW-1:0] i_req_data = '0;
    logic [NR-1:0]    i_req_valid = '0;
    logic [NR-1:0]    o_req_ready;
    logic [DW-1:0]    o_data;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [GW-1:0]    o_grant_id;
    logic             o_sof, o_eof, o_busy;

    socket_frame_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .FRAME_LEN(FL)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_data  (i_req_data),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_grant_id  (o_grant_id),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  valid;
        logic        ready;
        logic        ev, sof, eof, busy;
        logic [1:0]  gid;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        int gid;
        int data;
    } hs_t;

    int   checks = 0;
    int   errors = 0;
    int   seq[NR];
    bit   m_busy;
    int   m_gid, m_cnt, m_last;
    hs_t  hs_log[$];
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic r, input logic ev, input logic sof,
                                input logic eof, input logic busy, input logic [1:0] gid,
                                input logic [15:0] d);
        return '{valid: v, ready: r, ev: ev, sof: sof, eof: eof, busy: busy, gid: gid, data: d};
    endfunction

    // Each source emits a tagged running count: requester tag in the top nibble.
    function automatic int src(input int k);
        return (k << 12) + seq[k];
    endfunction

    function automatic int pick();
        for (int d = 1; d <= NR; d++)
            if (i_req_valid[(m_last + d) % NR]) return (m_last + d) % NR;
        return m_last;
    endfunction

    task automatic drive_data();
        for (int k = 0; k < NR; k++) i_req_data[k*DW +: DW] = DW'(src(k));
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_gid  = 0;
        m_cnt  = 0;
        m_last = NR - 1;
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_ready     = 1'b0;
        for (int k = 0; k < NR; k++) seq[k] = 0;
        hs_log.delete();
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model on the edge.
    task automatic cyc();
        logic ev;
        int   exp_rdy;
        drive_data();
        #2;
        ev      = m_busy && i_req_valid[m_gid];
        exp_rdy = (ev && i_ready) ? (1 << m_gid) : 0;
        check("valid", 32'(o_valid), 32'(ev));
        check("req_ready", 32'(o_req_ready), exp_rdy);
        check("data", 32'(o_data), m_busy ? src(m_gid) : 0);
        check("sof_eof", 32'({o_sof, o_eof}), 32'({ev && m_cnt == 0, ev && m_cnt == FL - 1}));
        check("busy", 32'(o_busy), 32'(m_busy));
        check("grant_id", 32'(o_grant_id), m_gid);
        if (o_valid && i_ready) hs_log.push_back('{gid: int'(o_grant_id), data: int'(o_data)});
        @(posedge i_clk);
        if (!m_busy) begin
            if (|i_req_valid) begin
                m_gid  = pick();
                m_busy = 1;
            end
        end else if (ev && i_ready) begin
            seq[m_gid]++;
            m_cnt++;
            if (m_cnt == FL) begin
                m_cnt  = 0;
                m_last = m_gid;
                m_busy = 0;
            end
        end
        #1;
    endtask

    initial begin
        tbl[0]  = mk(3'b010, 1, 0, 0, 0, 0, 2'd0, 16'h0000);
        tbl[1]  = mk(3'b010, 1, 1, 1, 0, 1, 2'd1, 16'h1000);
        tbl[2]  = mk(3'b010, 1, 1, 0, 0, 1, 2'd1, 16'h1001);
        tbl[3]  = mk(3'b010, 1, 1, 0, 0, 1, 2'd1, 16'h1002);
        tbl[4]  = mk(3'b010, 1, 1, 0, 0, 1, 2'd1, 16'h1003);
        tbl[5]  = mk(3'b010, 1, 1, 0, 1, 1, 2'd1, 16'h1004);
        tbl[6]  = mk(3'b010, 1, 0, 0, 0, 0, 2'd1, 16'h0000);
        tbl[7]  = mk(3'b010, 1, 1, 1, 0, 1, 2'd1, 16'h1005);
        tbl[8]  = mk(3'b010, 1, 1, 0, 0, 1, 2'd1, 16'h1006);
        tbl[9]  = mk(3'b010, 1, 1, 0, 0, 1, 2'd1, 16'h1007);
        tbl[10] = mk(3'b010, 1, 1, 0, 0, 1, 2'd1, 16'h1008);
        tbl[11] = mk(3'b010, 1, 1, 0, 1, 1, 2'd1, 16'h1009);
        tbl[12] = mk(3'b010, 1, 0, 0, 0, 0, 2'd1, 16'h0000);

        // Idle with no requests, ready toggling
        do_reset();
        for (int i = 0; i < 20; i++) begin
            i_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        check("idle_end", 32'({o_valid, o_busy, o_grant_id}), 32'(0));

        // Single requester, back-to-back frames with one bubble
        do_reset();
        for (int i = 0; i < 13; i++) begin
            i_req_valid = tbl[i].valid;
            i_ready     = tbl[i].ready;
            drive_data();
            #1;
            check($sformatf("tbl%0d", i), 32'({o_valid, o_sof, o_eof, o_busy, o_grant_id, o_data}),
                  32'({tbl[i].ev, tbl[i].sof, tbl[i].eof, tbl[i].busy, tbl[i].gid, tbl[i].data}));
            cyc();
        end

        // All requesting: grant order 0,1,2,0,1,2 in whole frames
        do_reset();
        i_req_valid = 3'b111;
        i_ready     = 1'b1;
        repeat (37) cyc();
        check("rr_words", 32'(hs_log.size() >= 30), 32'(1));
        for (int i = 0; i < 30 && i < hs_log.size(); i++) begin
            check($sformatf("rr_gid%0d", i), hs_log[i].gid, (i / 5) % 3);
            check($sformatf("rr_data%0d", i), hs_log[i].data, (((i / 5) % 3) << 12) + (i / 15) * 5 + i % 5);
        end

        // Downstream stall after the second word
        do_reset();
        i_req_valid = 3'b001;
        i_ready     = 1'b1;
        repeat (3) cyc();
        i_ready = 1'b0;
        repeat (3) cyc();
        check("stall_words", hs_log.size(), 2);
        check("stall_ready", 32'(o_req_ready), 32'(0));
        i_ready = 1'b1;
        repeat (4) cyc();
        check("stall_total", hs_log.size(), 5);
        for (int i = 0; i < 5 && i < hs_log.size(); i++)
            check($sformatf("stall_data%0d", i), hs_log[i].data, i);

        // Owner drops valid mid-frame: grant stays locked
        do_reset();
        i_req_valid = 3'b100;
        i_ready     = 1'b1;
        cyc();
        i_req_valid = 3'b101;
        repeat (3) cyc();
        i_req_valid = 3'b001;
        repeat (4) cyc();
        check("lock_valid", 32'(o_valid), 32'(0));
        check("lock_gid", 32'(o_grant_id), 32'(2));
        i_req_valid = 3'b101;
        repeat (4) cyc();
        check("lock_words", hs_log.size(), 6);
        for (int i = 0; i < 6 && i < hs_log.size(); i++)
            check($sformatf("lock_gid%0d", i), hs_log[i].gid, i < 5 ? 2 : 0);

        // Asynchronous reset during the third word of a frame from requester 1
        do_reset();
        i_req_valid = 3'b010;
        i_ready     = 1'b1;
        repeat (3) cyc();
        drive_data();
        #1;
        check("pre_rst_valid", 32'({o_valid, o_grant_id}), 32'({1'b1, 2'd1}));
        i_rst_n = 1'b0;
        #1;
        check("async_rst", 32'({o_valid, o_req_ready, o_sof, o_eof, o_busy, o_grant_id, o_data}), 32'(0));
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n     = 1'b1;
        i_req_valid = 3'b011;
        cyc();
        check("rst_tie_gid", 32'({o_grant_id, o_sof}), 32'({2'd0, 1'b1}));
        repeat (6) cyc();

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NR; k++) i_req_valid[k] = $urandom_range(0, 9) < 8;
            i_ready = $urandom_range(0, 3) != 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/socket_frame_arbiter.md
Name: socket_frame_arbiter

Overview:
- Shares one downstream socket between N_REQ producer modules.
- Arbitration is round-robin at frame granularity: once a requester is granted, it keeps the socket for exactly FRAME_LEN words. The output then re-arbitrates.
- Sits between several mod instances and a single socket instance, so several processing chains can feed one consumer without interleaving words inside a frame.

Parameters:
- DATA_WIDTH, 16, width of each data word.
- N_REQ, 3, number of requesters (2..8).
- FRAME_LEN, 5, words per frame; matches SOCKET_SIZE (>=1).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_req_data  in  N_REQ*DATA_WIDTH  per-requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_valid  in  N_REQ  per-requester word-available flag.
- o_req_ready  out  N_REQ  per-requester pop strobe.
- o_data  out  DATA_WIDTH  data toward the downstream socket.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream socket not full.
- o_grant_id  out  $clog2(N_REQ)  index of the current owner.
- o_sof  out  1  first word of a frame.
- o_eof  out  1  last word of a frame.
- o_busy  out  1  a frame transfer is in progress.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - o_grant_id=0, word counter=0, o_busy=0.
  - Last-served pointer = N_REQ-1, so requester 0 has first priority.
  - Combinational outputs evaluate to o_valid=0, o_req_ready=0, o_sof=0, o_eof=0, o_data=0.
- A handshake occurs on a cycle where o_valid && i_ready.
- States:
  - IDLE:
    - No grant; all o_req_ready=0; o_valid=0.
    - If any i_req_valid is set, pick the first set bit searching from (last+1) mod N_REQ upward with wrap.
    - Register the choice into o_grant_id and go to XFER on the next edge. Arbitration latency is 1 cycle.
    - If no request is pending, stay in IDLE.
  - XFER:
    - o_busy=1.
    - o_valid = i_req_valid[g] and o_data = i_req_data[g], combinational with zero added latency.
    - o_req_ready[g] = i_ready && i_req_valid[g]; all other ready bits are 0.
    - The counter increments on each handshake only. Stalls on either side hold the counter.
  - Frame end: on a handshake with counter==FRAME_LEN-1:
    - counter returns to 0;
    - last-served pointer takes g;
    - state returns to IDLE.
    - This gives exactly one bubble cycle between frames, including when the same requester is re-granted.
- Framing outputs:
  - o_sof = XFER && counter==0 && o_valid.
  - o_eof = XFER && counter==FRAME_LEN-1 && o_valid.
  - When FRAME_LEN==1, both are asserted on the same word.
- Grant locking: the grant is never revoked mid-frame. If the owner drops i_req_valid, the block waits indefinitely and no other requester is served.
- Simultaneous requests: resolved purely by the rotating priority. No requester waits more than N_REQ-1 frames.
- Ready/valid dependency: i_ready has no effect in IDLE. o_valid never depends on i_ready.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned and the downstream socket keeps the words already pushed.
- Width: counter is $clog2(FRAME_LEN+1) bits. o_grant_id is $clog2(N_REQ) bits, minimum 1.

Decomposition:
- Package pck_arbiter, holding:
  - the state typedef (enum logic {IDLE, XFER});
  - the function clog2_min1(n);
  - the rotating-priority search function next_grant(req, last).
- One sub-module is natural: rr_pointer_arbiter. It is purely combinational plus the last-served register, and is reusable for other shared resources.
- The FSM, counter and data mux stay in socket_frame_arbiter.

Test Plan:
1. Reset, then hold all i_req_valid=0 for 20 cycles -> o_valid=0, o_busy=0, o_grant_id=0 throughout.
2. Only req1 valid continuously, i_ready=1:
   - o_grant_id=1 one cycle after the request.
   - 5 words pass, with o_sof on the 1st and o_eof on the 5th.
   - 1 bubble, then req1 is re-granted.
   - Data matches the source counter sequence 0,1,2,3,4 / 5,6,7,8,9.
3. All 3 valid continuously from reset -> grant order 0,1,2,0,1,2. Each burst is exactly 5 handshakes, with no interleaving.
4. Grant 0 active, i_ready deasserted for 3 cycles after word 2 -> counter holds at 2, o_req_ready[0]=0, no words lost or duplicated, frame completes with 5 words.
5. Owner 2 drops i_req_valid after word 3 while req0 is valid -> o_valid=0, grant stays 2 and req0 is not served. When req2 resumes, words 4-5 complete and req0 is granted next.
6. Assert i_rst_n=0 asynchronously during word 3 of a frame from req1 -> outputs go to reset values before the next edge. After release, requester 0 wins a tie against req1.
